vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Upstream raster stage for the sprite/colour mappers: generates pixel
//   coordinates DrawX/DrawY, the visible-area flag blank and the VGA syncs.
// - Default mode is 640x480@60 (800x525 total, 25 MHz vga_clk).
// - Syncs are delayed by SYNC_DELAY clocks so they line up with mapper colour
//   output (ROM read + output register = 2 clocks).
// - frame_cnt is a free-running frame counter used for sprite animation.
// PARAMETERS
// H_VIS      640  visible pixels per line
// H_FP        16  horizontal front porch, clocks
// H_SYNC      96  horizontal sync width, clocks
// H_BP        48  horizontal back porch, clocks (H_TOT = 800)
// V_VIS      480  visible lines
// V_FP        10  vertical front porch, lines
// V_SYNC       2  vertical sync width, lines
// V_BP        33  vertical back porch, lines (V_TOT = 525)
// SYNC_DELAY   2  pipeline stages on hs/vs; range 0..4
// PORTS
// vga_clk      in   1   pixel clock; all logic on its rising edge
// reset_n      in   1   synchronous reset, active-low
// DrawX        out  10  horizontal counter hc, 0..H_TOT-1
// DrawY        out  10  vertical counter vc, 0..V_TOT-1
// blank        out  1   1 = visible pixel (hc<H_VIS && vc<V_VIS), 0 = blanked
// hs           out  1   horizontal sync, active-low, delayed SYNC_DELAY clocks
// vs           out  1   vertical sync, active-low, delayed SYNC_DELAY clocks
// frame_start  out  1   1-clock pulse while hc==0 && vc==0
// frame_cnt    out  8   frames completed since reset; wraps 255->0
// BEHAVIOUR
// - Reset: with reset_n==0 at a clock edge, the next state is:
//   hc=0, vc=0, frame_cnt=0, all hs/vs delay stages =1.
//   So after that edge: DrawX=0, DrawY=0, blank=1, frame_start=1, hs=1, vs=1.
//   Mid-frame reset has the same effect; the raster restarts at (0,0) next clock.
// - Horizontal counter: hc increments every clock; at H_TOT-1 it wraps to 0.
// - Vertical counter: vc increments only on the hc wrap; at vc==V_TOT-1 with
//   hc==H_TOT-1, vc wraps to 0.
// - frame_cnt: increments on the same edge where both counters wrap
//   (8-bit modular).
// - DrawX/DrawY: are the hc/vc registers directly (0 cycles latency).
// - blank, frame_start: combinational decode of the current hc/vc, same cycle.
// - Raw sync decode: hs_raw=0 iff H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC
//   (656..751); vs_raw=0 iff V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (490..491).
//   vs_raw depends on vc only, so it spans whole lines.
// - Sync delay: hs/vs = hs_raw/vs_raw passed through a SYNC_DELAY-stage register
//   chain. SYNC_DELAY=0 means combinational pass-through.
//   Chain registers reset to 1 (inactive).
// - Widths: counters are 10 bits; all parameter sums must be < 1024.
//   Compares are unsigned.
// - No input handshake: the block free-runs whenever reset_n==1.
//   Consumers sample DrawX/DrawY/blank every clock.
// TESTING
// - Reset release: hold reset_n=0 for 3 clocks, then release ->
//   DrawX=0, DrawY=0, blank=1, frame_start=1, hs=1, vs=1, frame_cnt=0.
// - Line timing: count clocks between hs falling edges -> 800.
//   hs low for 96 clocks; hs falls SYNC_DELAY clocks after the cycle where DrawX==656.
// - Visible window: blank==1 for exactly 640x480 = 307200 clocks per frame.
//   blank=0 at DrawX=640,DrawY=0 and at DrawX=0,DrawY=480.
// - Frame wrap: at DrawX=799,DrawY=524 -> next clock DrawX=0, DrawY=0,
//   frame_start=1, frame_cnt +1. Run 256 frames -> frame_cnt back to 0.
// - Vsync: vs low for 2x800 = 1600 clocks, starting SYNC_DELAY clocks after
//   DrawX=0,DrawY=490. Frame period between vs falls = 420000 clocks.
// - Mid-frame reset: pulse reset_n=0 for 1 clock at DrawX=300,DrawY=200 ->
//   next clock DrawX=0, DrawY=0, frame_cnt=0, delayed hs/vs forced to 1.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_if
//  Purpose  : Raster output bundle from the VGA timing generator to the
//             sprite/colour mappers and the VGA connector.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    DrawX        10  current horizontal position (pixel clocks into line)
//    DrawY        10  current vertical position (lines into frame)
//    blank         1  1 = visible pixel, 0 = blanked
//    hs            1  horizontal sync, active-low, pipeline-aligned
//    vs            1  vertical sync, active-low, pipeline-aligned
//    frame_start   1  high for the single clock at (0,0)
//    frame_cnt     8  frames completed since reset, wraps
//  Modports
//    master  : the timing generator (drives everything)
//    slave   : any raster consumer (samples everything)
// ============================================================================
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    output DrawX, DrawY, blank, hs, vs, frame_start, frame_cnt
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, frame_start, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Free-running raster generator. Produces the pixel coordinates,
//             visible-area flag and VGA syncs for the mapper pipeline, plus a
//             frame counter for sprite animation. Default mode 640x480@60.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    vga_clk   in   pixel clock, everything on its rising edge
//    reset_n   in   synchronous reset, active-low
//    vga       out  raster bundle (vga_timing_gen_if.master)
//  Parameter sums (H_VIS+H_FP+H_SYNC+H_BP etc.) must stay below 1024 since
//  the counters are 10 bits; SYNC_DELAY is intended for 0..4.
// ============================================================================
module vga_timing_gen #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  vga_timing_gen_if.master   vga
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
  localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0] hc;
  logic [9:0] vc;
  logic [7:0] frame_cnt;
  logic       hs_raw;
  logic       vs_raw;

  // Raster counters. vc only moves on the hc wrap, and the frame counter
  // only on the edge where both wrap together.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc        <= '0;
      vc        <= '0;
      frame_cnt <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      if (vc == V_LAST) begin
        vc        <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        vc <= vc + 10'd1;
      end
    end else begin
      hc <= hc + 10'd1;
    end
  end

  // Undelayed sync decode; vs_raw ignores hc so it covers whole lines.
  assign hs_raw = !((hc >= HS_START) && (hc < HS_END));
  assign vs_raw = !((vc >= VS_START) && (vc < VS_END));

  // Syncs are delayed to line up with colour data leaving the mappers
  // (ROM read + output register). The chain resets to the inactive level so
  // no spurious sync pulse appears while the pipeline refills after reset.
  generate
    if (SYNC_DELAY == 0) begin : g_sync_direct
      assign vga.hs = hs_raw;
      assign vga.vs = vs_raw;
    end else begin : g_sync_pipe
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;

      always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
        end else begin
          hs_pipe[0] <= hs_raw;
          vs_pipe[0] <= vs_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
          end
        end
      end

      assign vga.hs = hs_pipe[SYNC_DELAY-1];
      assign vga.vs = vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

  // Coordinates are the counters themselves; blank/frame_start are decoded
  // from the same cycle's counters so consumers need no extra alignment.
  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.blank       = (hc < H_VIS_END) && (vc < V_VIS_END);
  assign vga.frame_start = (hc == '0) && (vc == '0);
  assign vga.frame_cnt   = frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. Uses a reduced raster
//             (20x12 total, 12x6 visible) so full frames and the 256-frame
//             counter wrap fit in a short run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HV = 12, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 2;
  localparam int D  = 2;
  localparam int HT = HV + HF + HS + HB;   // 20
  localparam int VT = VV + VF + VS + VB;   // 12
  localparam int FT = HT * VT;             // 240

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [7:0] fc;
  } out_t;

  typedef struct {
    int   t;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   t = 0;          // clocks since the last reset edge
  int   checks = 0;
  int   errors = 0;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_DELAY(D)
  ) dut (
    .vga_clk (clk),
    .reset_n (reset_n),
    .vga     (vif)
  );

  always #5 clk = ~clk;

  // Reference: everything follows from elapsed time since reset.
  function automatic out_t ref_at(input int tt);
    out_t o;
    int hp, vp, td, hd, vd;
    hp = tt % HT;
    vp = (tt / HT) % VT;
    o.x     = 10'(hp);
    o.y     = 10'(vp);
    o.blank = (hp < HV) && (vp < VV);
    o.fs    = (hp == 0) && (vp == 0);
    o.fc    = 8'((tt / FT) % 256);
    if (tt >= D) begin
      td   = tt - D;
      hd   = td % HT;
      vd   = (td / HT) % VT;
      o.hs = !((hd >= HV + HF) && (hd < HV + HF + HS));
      o.vs = !((vd >= VV + VF) && (vd < VV + VF + VS));
    end else begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.x = vif.DrawX; o.y = vif.DrawY; o.blank = vif.blank;
    o.fs = vif.frame_start; o.hs = vif.hs; o.vs = vif.vs; o.fc = vif.frame_cnt;
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("x=%0d y=%0d blank=%0b fs=%0b hs=%0b vs=%0b fc=%0d",
                     o.x, o.y, o.blank, o.fs, o.hs, o.vs, o.fc);
  endfunction

  function automatic out_t mk(input int x, input int y, input bit b, input bit fs,
                              input bit h, input bit v, input int fc);
    out_t o;
    o.x = 10'(x); o.y = 10'(y); o.blank = b; o.fs = fs;
    o.hs = h; o.vs = v; o.fc = 8'(fc);
    return o;
  endfunction

  task automatic chk_out(input string name, input out_t exp);
    out_t act;
    act = dut_out();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got {%s} expected {%s}", name, t, fmt(act), fmt(exp));
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; reset_n is sampled at the edge, outputs read 1 ns later.
  task automatic step();
    logic rs;
    rs = reset_n;
    @(posedge clk);
    #1;
    if (!rs) t = 0;
    else     t++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  vec_t vec[15];

  initial begin
    int   cnt, t1, t2, n;
    logic prev;
    bit   found;

    // {t since reset, expected outputs}
    vec[0]  = '{0,   mk(0,  0,  1, 1, 1, 1, 0)};
    vec[1]  = '{1,   mk(1,  0,  1, 0, 1, 1, 0)};
    vec[2]  = '{11,  mk(11, 0,  1, 0, 1, 1, 0)};
    vec[3]  = '{12,  mk(12, 0,  0, 0, 1, 1, 0)};
    vec[4]  = '{16,  mk(16, 0,  0, 0, 0, 1, 0)};
    vec[5]  = '{18,  mk(18, 0,  0, 0, 0, 1, 0)};
    vec[6]  = '{19,  mk(19, 0,  0, 0, 1, 1, 0)};
    vec[7]  = '{20,  mk(0,  1,  1, 0, 1, 1, 0)};
    vec[8]  = '{120, mk(0,  6,  0, 0, 1, 1, 0)};
    vec[9]  = '{162, mk(2,  8,  0, 0, 1, 0, 0)};
    vec[10] = '{199, mk(19, 9,  0, 0, 1, 0, 0)};
    vec[11] = '{202, mk(2,  10, 0, 0, 1, 1, 0)};
    vec[12] = '{239, mk(19, 11, 0, 0, 1, 1, 0)};
    vec[13] = '{240, mk(0,  0,  1, 1, 1, 1, 1)};
    vec[14] = '{496, mk(16, 0,  0, 0, 0, 1, 2)};

    // ---- table-driven vectors from reset release ----
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run_to(vec[i].t);
      chk_out($sformatf("vec%0d", i), vec[i].exp);
    end

    // ---- line timing: hs period, width and alignment ----
    do_reset();
    prev = vif.hs; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (prev && !vif.hs) found = 1;
      prev = vif.hs;
    end
    chk_int("hs_fall_seen", int'(found), 1);
    chk_int("hs_fall_drawx", int'(vif.DrawX), HV + HF + D);
    t1 = t; n = 0;
    while (!vif.hs && n < 100) begin step(); n++; end
    chk_int("hs_low_width", n, HS);
    prev = vif.hs; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (prev && !vif.hs) found = 1;
      prev = vif.hs;
    end
    chk_int("hs_period", t - t1, HT);

    // ---- vsync width, alignment and frame period ----
    do_reset();
    prev = vif.vs; found = 0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      step();
      if (prev && !vif.vs) found = 1;
      prev = vif.vs;
    end
    chk_int("vs_fall_seen", int'(found), 1);
    chk_out("vs_fall_pos", mk(D, VV + VF, 0, 0, 1, 0, 0));
    t1 = t; n = 0;
    while (!vif.vs && n < 2 * FT) begin step(); n++; end
    chk_int("vs_low_width", n, VS * HT);
    prev = vif.vs; t2 = -1;
    for (int i = 0; i < 2 * FT && t2 < 0; i++) begin
      step();
      if (prev && !vif.vs) t2 = t;
      prev = vif.vs;
    end
    chk_int("vs_period", t2 - t1, FT);

    // ---- visible window size over one frame ----
    do_reset();
    cnt = 0;
    for (int i = 0; i < FT; i++) begin
      cnt += int'(vif.blank);
      step();
    end
    chk_int("visible_clocks", cnt, HV * VV);

    // ---- mid-frame reset while hs is low and frame_cnt nonzero ----
    do_reset();
    run_to(FT + 3 * HT + 16);
    chk_out("pre_midreset", mk(16, 3, 0, 0, 0, 1, 1));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk_out("midreset_0", mk(0, 0, 1, 1, 1, 1, 0));
    step();
    chk_out("midreset_1", mk(1, 0, 1, 0, 1, 1, 0));

    // ---- 256 frames: counter wraps back to zero ----
    do_reset();
    run_to(255 * FT);
    chk_out("frame_255", mk(0, 0, 1, 1, 1, 1, 255));
    run_to(256 * FT - 1);
    chk_out("frame_last_px", mk(HT - 1, VT - 1, 0, 0, 1, 1, 255));
    step();
    chk_out("frame_wrap", mk(0, 0, 1, 1, 1, 1, 0));

    // ---- random reset pulses against the time-based model ----
    do_reset();
    for (int i = 0; i < 15000; i++) begin
      reset_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      step();
      chk_out("random", ref_at(t));
    end
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
